// File: rtl/lcd_pkg.sv
// Shared command encodings and controller state type for the LCD image controller.
package lcd_pkg;

  localparam logic [3:0] CMD_WRITE  = 4'd0;
  localparam logic [3:0] CMD_UP     = 4'd1;
  localparam logic [3:0] CMD_DOWN   = 4'd2;
  localparam logic [3:0] CMD_LEFT   = 4'd3;
  localparam logic [3:0] CMD_RIGHT  = 4'd4;
  localparam logic [3:0] CMD_AVG    = 4'd5;
  localparam logic [3:0] CMD_MIRX   = 4'd6;
  localparam logic [3:0] CMD_MIRY   = 4'd7;
  localparam logic [3:0] CMD_ROTCW  = 4'd8;
  localparam logic [3:0] CMD_MAX    = 4'd9;
  localparam logic [3:0] CMD_MIN    = 4'd10;
  localparam logic [3:0] CMD_RELOAD = 4'd11;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: maps the four window pixels and a command
// to the four replacement pixels plus a write strobe.
module lcd_win_alu
  import lcd_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [3:0]    cmd,
  input  logic [DW-1:0] tl,
  input  logic [DW-1:0] tr,
  input  logic [DW-1:0] bl,
  input  logic [DW-1:0] br,
  output logic [DW-1:0] tl_c,
  output logic [DW-1:0] tr_c,
  output logic [DW-1:0] bl_c,
  output logic [DW-1:0] br_c,
  output logic          we_c
);

  logic [DW+1:0] sum;
  logic [DW-1:0] avg;
  logic [DW-1:0] mx_t, mx_b, mx;
  logic [DW-1:0] mn_t, mn_b, mn;

  // Two guard bits keep the four-pixel sum exact.
  always_comb begin
    sum  = (DW+2)'(tl) + (DW+2)'(tr) + (DW+2)'(bl) + (DW+2)'(br);
    avg  = DW'(sum >> 2);
    mx_t = (tl > tr) ? tl : tr;
    mx_b = (bl > br) ? bl : br;
    mx   = (mx_t > mx_b) ? mx_t : mx_b;
    mn_t = (tl < tr) ? tl : tr;
    mn_b = (bl < br) ? bl : br;
    mn   = (mn_t < mn_b) ? mn_t : mn_b;
  end

  always_comb begin
    tl_c = tl;
    tr_c = tr;
    bl_c = bl;
    br_c = br;
    we_c = 1'b1;
    case (cmd)
      CMD_AVG:   begin tl_c = avg; tr_c = avg; bl_c = avg; br_c = avg; end
      CMD_MIRX:  begin tl_c = bl;  tr_c = br;  bl_c = tl;  br_c = tr;  end
      CMD_MIRY:  begin tl_c = tr;  tr_c = tl;  bl_c = br;  br_c = bl;  end
      CMD_ROTCW: begin tl_c = bl;  tr_c = tl;  br_c = tr;  bl_c = br;  end
      CMD_MAX:   begin tl_c = mx;  tr_c = mx;  bl_c = mx;  br_c = mx;  end
      CMD_MIN:   begin tl_c = mn;  tr_c = mn;  bl_c = mn;  br_c = mn;  end
      default:   we_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_p.sv
// Parametrised LCD image controller: loads an image from IROM, applies window
// commands from the host and streams the image out to IRB.
module lcd_ctrl_p
  import lcd_pkg::*;
#(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] IROM_Q,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [DW-1:0] IRB_D,
  output logic [AW-1:0] IRB_A,
  output logic          busy,
  output logic          done
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = AW - XW;
  localparam int unsigned CW = AW + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          irom_en_q, irom_en_d;
  logic [AW-1:0] irom_a_q, irom_a_d;
  logic          irb_rw_q, irb_rw_d;
  logic [DW-1:0] irb_d_q, irb_d_d;
  logic [AW-1:0] irb_a_q, irb_a_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [DW-1:0] mem_q [N];

  logic          load_we_c;
  logic [AW-1:0] load_wa_c;
  logic          win_we_c;

  // Window addresses: IMG_W is a power of two, so y*IMG_W + x is {y, x}.
  logic [XW-1:0] x_left;
  logic [YW-1:0] y_top;
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  logic [DW-1:0] px_tl, px_tr, px_bl, px_br;
  logic [DW-1:0] new_tl, new_tr, new_bl, new_br;
  logic          alu_we;

  assign x_left = ox_q - XW'(1);
  assign y_top  = oy_q - YW'(1);
  assign a_tl   = {y_top, x_left};
  assign a_tr   = {y_top, ox_q};
  assign a_bl   = {oy_q, x_left};
  assign a_br   = {oy_q, ox_q};
  assign px_tl  = mem_q[a_tl];
  assign px_tr  = mem_q[a_tr];
  assign px_bl  = mem_q[a_bl];
  assign px_br  = mem_q[a_br];

  lcd_win_alu #(.DW(DW)) u_alu (
    .cmd  (cmd_q),
    .tl   (px_tl),
    .tr   (px_tr),
    .bl   (px_bl),
    .br   (px_br),
    .tl_c (new_tl),
    .tr_c (new_tr),
    .bl_c (new_bl),
    .br_c (new_br),
    .we_c (alu_we)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      ox_q      <= XW'(IMG_W / 2);
      oy_q      <= YW'(IMG_H / 2);
      cmd_q     <= '0;
      irom_en_q <= 1'b1;
      irom_a_q  <= '0;
      irb_rw_q  <= 1'b1;
      irb_d_q   <= '0;
      irb_a_q   <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      cmd_q     <= cmd_d;
      irom_en_q <= irom_en_d;
      irom_a_q  <= irom_a_d;
      irb_rw_q  <= irb_rw_d;
      irb_d_q   <= irb_d_d;
      irb_a_q   <= irb_a_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Pixel storage has no reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (load_we_c) mem_q[load_wa_c] <= IROM_Q;
      if (win_we_c) begin
        mem_q[a_tl] <= new_tl;
        mem_q[a_tr] <= new_tr;
        mem_q[a_bl] <= new_bl;
        mem_q[a_br] <= new_br;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    cmd_d     = cmd_q;
    irom_en_d = 1'b1;
    irom_a_d  = '0;
    irb_rw_d  = 1'b1;
    irb_d_d   = '0;
    irb_a_d   = '0;
    load_we_c = 1'b0;
    load_wa_c = '0;
    win_we_c  = 1'b0;

    case (state_q)
      // Address leads by one cycle and ROM data by another: capture trails cnt by two.
      ST_LOAD: begin
        if (cnt_q >= CW'(2)) begin
          load_we_c = 1'b1;
          load_wa_c = AW'(cnt_q - CW'(2));
        end
        if (cnt_q < CW'(N)) begin
          irom_en_d = 1'b0;
          irom_a_d  = AW'(cnt_q);
        end
        if (cnt_q == CW'(N + 1)) state_d = ST_IDLE;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      ST_IDLE: begin
        if (cmd_valid && !busy_q) begin
          cmd_d = cmd;
          cnt_d = '0;
          if (cmd == CMD_WRITE)       state_d = ST_WRITE;
          else if (cmd == CMD_RELOAD) state_d = ST_LOAD;
          else                        state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d  = ST_IDLE;
        win_we_c = alu_we;
        case (cmd_q)
          CMD_UP:    if (oy_q > YW'(1))         oy_d = oy_q - YW'(1);
          CMD_DOWN:  if (oy_q < YW'(IMG_H - 1)) oy_d = oy_q + YW'(1);
          CMD_LEFT:  if (ox_q > XW'(1))         ox_d = ox_q - XW'(1);
          CMD_RIGHT: if (ox_q < XW'(IMG_W - 1)) ox_d = ox_q + XW'(1);
          default:   ;
        endcase
      end
      ST_WRITE: begin
        if (cnt_q == CW'(N - 1)) state_d = ST_DONE;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // IRB outputs are registered alongside the state that owns them.
    if (state_d == ST_WRITE) begin
      irb_rw_d = 1'b0;
      irb_a_d  = AW'(cnt_d);
      irb_d_d  = mem_q[AW'(cnt_d)];
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign IROM_EN = irom_en_q;
  assign IROM_A  = irom_a_q;
  assign IRB_RW  = irb_rw_q;
  assign IRB_D   = irb_d_q;
  assign IRB_A   = irb_a_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
